jtag_tap_responder: RTL and testbench

Responder-side JTAG TAP controller: the device end of the `jtag_a` bus. It samples `tck`/`tms`/`tdi` in the system clock domain, runs the IEEE 1149.1 16-state TAP FSM, and holds an instruction register plus BYPASS, IDCODE and USER data registers. It drives `tdo` back to the initiator, and serves as the bench's reference DUT for `jtag_a` agent scans.

---
 rtl/jtag_tap_responder.sv | 219 +++++++++++++++++++++
 tb/tb_jtag_tap_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder
// Device-side JTAG TAP controller for the jtag_a bus. The TAP pins are
// oversampled in the system clock domain. tck edges are detected as events,
// and the 16-state TAP FSM advances only on those events.
//
// Data registers: BYPASS (1 bit), IDCODE (32 bits) and USER (DR_WIDTH bits).
//
// Ports:
//   clock       in   system clock (the only clock)
//   reset       in   synchronous active-low reset
//   tck         in   JTAG test clock, sampled as data
//   tms         in   test mode select
//   tdi         in   test data in
//   tdo         out  test data out, changes on tck fall events
//   tdo_en      out  high while tdo carries shift data
//   tap_state   out  TAP state, 1149.1 encoding
//   ir_out      out  active instruction
//   user_in     in   value captured into USER in Capture-DR
//   user_out    out  USER value latched in Update-DR
//   user_update out  one-clock pulse when user_out loads
module jtag_tap_responder #(
    parameter int unsigned         IR_WIDTH   = 4,
    parameter int unsigned         DR_WIDTH   = 16,
    parameter logic [31:0]         IDCODE_VAL = 32'h4BA0_0477,
    parameter logic [IR_WIDTH-1:0] OP_IDCODE  = 4'h1,
    parameter logic [IR_WIDTH-1:0] OP_USER    = 4'h8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_out,
    input  logic [DR_WIDTH-1:0] user_in,
    output logic [DR_WIDTH-1:0] user_out,
    output logic                user_update
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    // Pattern loaded into the IR in Capture-IR: binary ...0001.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]          tck_sync_r;
    logic [1:0]          tms_sync_r;
    logic [1:0]          tdi_sync_r;
    logic                tck_prev_r;
    logic                rise_r;
    logic                fall_r;
    tap_state_e          state_r;
    logic [IR_WIDTH-1:0] ir_shift_r;
    logic                bypass_r;
    logic [31:0]         idcode_shift_r;
    logic [DR_WIDTH-1:0] user_shift_r;
    logic                sel_idcode_s;
    logic                sel_user_s;
    logic                dr_bit0_s;

    // IEEE 1149.1 next-state function, evaluated on a tck rise event.
    function automatic tap_state_e tap_next(input tap_state_e cur, input logic tms_v);
        tap_state_e nxt;
        case (cur)
            TLR:    nxt = tms_v ? TLR    : RTI;
            RTI:    nxt = tms_v ? SEL_DR : RTI;
            SEL_DR: nxt = tms_v ? SEL_IR : CAP_DR;
            CAP_DR: nxt = tms_v ? EX1_DR : SH_DR;
            SH_DR:  nxt = tms_v ? EX1_DR : SH_DR;
            EX1_DR: nxt = tms_v ? UPD_DR : PAU_DR;
            PAU_DR: nxt = tms_v ? EX2_DR : PAU_DR;
            EX2_DR: nxt = tms_v ? UPD_DR : SH_DR;
            UPD_DR: nxt = tms_v ? SEL_DR : RTI;
            SEL_IR: nxt = tms_v ? TLR    : CAP_IR;
            CAP_IR: nxt = tms_v ? EX1_IR : SH_IR;
            SH_IR:  nxt = tms_v ? EX1_IR : SH_IR;
            EX1_IR: nxt = tms_v ? UPD_IR : PAU_IR;
            PAU_IR: nxt = tms_v ? EX2_IR : PAU_IR;
            EX2_IR: nxt = tms_v ? UPD_IR : SH_IR;
            UPD_IR: nxt = tms_v ? SEL_DR : RTI;
            default: nxt = TLR;
        endcase
        return nxt;
    endfunction

    // Synchronize the TAP pins and turn tck transitions into one-clock events.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tck_sync_r <= 2'b00;
            tms_sync_r <= 2'b00;
            tdi_sync_r <= 2'b00;
            tck_prev_r <= 1'b0;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
        end else begin
            tck_sync_r <= {tck_sync_r[0], tck};
            tms_sync_r <= {tms_sync_r[0], tms};
            tdi_sync_r <= {tdi_sync_r[0], tdi};
            tck_prev_r <= tck_sync_r[1];
            rise_r     <= tck_sync_r[1] & ~tck_prev_r;
            fall_r     <= ~tck_sync_r[1] & tck_prev_r;
        end
    end

    // The DR is chosen from the active instruction. That instruction only
    // changes in Update-IR and Test-Logic-Reset, so it cannot change mid-scan.
    always_comb begin
        sel_idcode_s = 1'b0;
        sel_user_s   = 1'b0;
        if (ir_out == OP_IDCODE) begin
            sel_idcode_s = 1'b1;
        end else if (ir_out == OP_USER) begin
            sel_user_s = 1'b1;
        end else begin
            sel_idcode_s = 1'b0;
            sel_user_s   = 1'b0;
        end
    end

    // Bit 0 of the selected data register, which is driven to tdo during Shift-DR.
    always_comb begin
        dr_bit0_s = 1'b0;
        if (sel_idcode_s) begin
            dr_bit0_s = idcode_shift_r[0];
        end else if (sel_user_s) begin
            dr_bit0_s = user_shift_r[0];
        end else begin
            dr_bit0_s = bypass_r;
        end
    end

    // TAP FSM. Capture and shift act on rise events, and update and tdo act on
    // fall events. Each action is chosen by the state the TAP is in at that event.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r        <= TLR;
            ir_shift_r     <= {IR_WIDTH{1'b0}};
            bypass_r       <= 1'b0;
            idcode_shift_r <= 32'h0000_0000;
            user_shift_r   <= {DR_WIDTH{1'b0}};
            tdo            <= 1'b0;
            tdo_en         <= 1'b0;
            ir_out         <= OP_IDCODE;
            user_out       <= {DR_WIDTH{1'b0}};
            user_update    <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (rise_r) begin
                case (state_r)
                    CAP_IR: ir_shift_r <= IR_CAPTURE;
                    SH_IR:  ir_shift_r <= {tdi_sync_r[1], ir_shift_r[IR_WIDTH-1:1]};
                    CAP_DR: begin
                        if (sel_idcode_s) begin
                            idcode_shift_r <= IDCODE_VAL;
                        end else if (sel_user_s) begin
                            user_shift_r <= user_in;
                        end else begin
                            bypass_r <= 1'b0;
                        end
                    end
                    SH_DR: begin
                        if (sel_idcode_s) begin
                            idcode_shift_r <= {tdi_sync_r[1], idcode_shift_r[31:1]};
                        end else if (sel_user_s) begin
                            user_shift_r <= {tdi_sync_r[1], user_shift_r[DR_WIDTH-1:1]};
                        end else begin
                            bypass_r <= tdi_sync_r[1];
                        end
                    end
                    default: ;
                endcase
                state_r <= tap_next(state_r, tms_sync_r[1]);
            end else if (fall_r) begin
                case (state_r)
                    SH_IR: begin
                        tdo    <= ir_shift_r[0];
                        tdo_en <= 1'b1;
                    end
                    SH_DR: begin
                        tdo    <= dr_bit0_s;
                        tdo_en <= 1'b1;
                    end
                    UPD_IR: begin
                        tdo    <= 1'b0;
                        tdo_en <= 1'b0;
                        ir_out <= ir_shift_r;
                    end
                    UPD_DR: begin
                        tdo    <= 1'b0;
                        tdo_en <= 1'b0;
                        if (sel_user_s) begin
                            user_out    <= user_shift_r;
                            user_update <= 1'b1;
                        end
                    end
                    TLR: begin
                        tdo    <= 1'b0;
                        tdo_en <= 1'b0;
                        ir_out <= OP_IDCODE;
                    end
                    default: begin
                        tdo    <= 1'b0;
                        tdo_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tap_state = state_r;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed testbench for jtag_tap_responder. A vector table drives an IR scan
// and a BYPASS DR scan. Hand-written sequences cover reset, IDCODE, USER,
// the TMS reset and a reset that aborts a scan.
module tb_jtag_tap_responder;

    localparam int PH = 6;  // clocks per tck phase

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tck = 1'b0;
    logic        tms = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic        tdo_en;
    logic [3:0]  tap_state;
    logic [3:0]  ir_out;
    logic [15:0] user_in = 16'h0000;
    logic [15:0] user_out;
    logic        user_update;

    int n_cmp  = 0;
    int n_fail = 0;
    int upd_cnt = 0;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic       exp_tdo;
        logic       exp_en;
        logic [3:0] exp_state;
    } vec_t;

    vec_t vecs [21];

    jtag_tap_responder dut (
        .clock       (clock),
        .reset       (reset),
        .tck         (tck),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .tap_state   (tap_state),
        .ir_out      (ir_out),
        .user_in     (user_in),
        .user_out    (user_out),
        .user_update (user_update)
    );

    always #5 clock = ~clock;

    // Count clocks with user_update high.
    always @(negedge clock) begin
        if (user_update === 1'b1) upd_cnt = upd_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One tck period: set tms/tdi in the low phase and sample tdo/tdo_en at the rising edge.
    task automatic pulse(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic en_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (PH) @(negedge clock);
        tdo_v = tdo;
        en_v  = tdo_en;
        tck = 1'b1;
        repeat (PH) @(negedge clock);
        tck = 1'b0;
    endtask

    task automatic move(input logic [7:0] seq, input int n);
        logic o, e;
        for (int i = 0; i < n; i++) pulse(seq[i], 1'b0, o, e);
    endtask

    task automatic scan(input int n, input logic [31:0] din, input logic do_exit,
                        output logic [31:0] dout, output int en_cnt);
        logic o, e;
        dout   = 32'h0;
        en_cnt = 0;
        for (int i = 0; i < n; i++) begin
            pulse((do_exit && (i == n - 1)) ? 1'b1 : 1'b0, din[i], o, e);
            dout[i] = o;
            if (e) en_cnt++;
        end
    endtask

    task automatic load_ir(input logic [3:0] op);
        logic [31:0] d;
        int ec;
        move(8'b0000_0011, 4);           // RTI -> SelDR -> SelIR -> CapIR -> ShIR
        scan(4, {28'h0, op}, 1'b1, d, ec);
        check("ir_capture", d[3:0], 4'h1);
        move(8'b0000_0001, 2);           // Ex1IR -> UpdIR -> RTI
    endtask

    task automatic idcode_read(input string tag);
        logic [31:0] d;
        int ec;
        logic o, e;
        pulse(1'b0, 1'b0, o, e);         // to RTI
        move(8'b0000_0001, 3);           // SelDR, CapDR, ShDR
        scan(32, 32'h0, 1'b1, d, ec);
        check({tag, "_bits"}, d, 32'h4BA0_0477);
        check({tag, "_en_cnt"}, ec, 32);
        pulse(1'b1, 1'b0, o, e);         // Ex1DR -> UpdDR
        check({tag, "_en_after"}, {31'h0, e}, 32'h0);
        pulse(1'b0, 1'b0, o, e);         // -> RTI
    endtask

    initial begin
        logic [31:0] d;
        int ec;
        int upd0;
        logic o, e;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hC};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h7};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h4};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hE};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hA};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hA};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hA};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hA};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h9};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hD};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hC};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h7};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h6};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h2};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h2};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h2};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h2};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h1};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h5};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hC};

        // Reset with tck toggling.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tck = ~tck;
        end
        tck = 1'b0;
        @(negedge clock);
        check("rst_state", tap_state, 4'hF);
        check("rst_ir", ir_out, 4'h1);
        check("rst_tdo", tdo, 1'b0);
        check("rst_tdo_en", tdo_en, 1'b0);
        check("rst_user_out", user_out, 16'h0000);
        check("rst_user_update", user_update, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        idcode_read("idcode1");

        // IR scan of 4'hF, then a BYPASS DR scan.
        for (int i = 0; i < 21; i++) begin
            pulse(vecs[i].tms, vecs[i].tdi, o, e);
            check($sformatf("vec%0d_tdo", i), o, vecs[i].exp_tdo);
            check($sformatf("vec%0d_en", i), e, vecs[i].exp_en);
            check($sformatf("vec%0d_state", i), tap_state, vecs[i].exp_state);
        end
        check("ir_after_table", ir_out, 4'hF);

        // USER scan.
        load_ir(4'h8);
        check("ir_user", ir_out, 4'h8);
        user_in = 16'h1234;
        upd0 = upd_cnt;
        move(8'b0000_0001, 3);
        scan(16, 32'h0000_A5C3, 1'b1, d, ec);
        check("user_tdo", d[15:0], 16'h1234);
        check("user_en_cnt", ec, 16);
        check("user_out_before", user_out, 16'h0000);
        pulse(1'b1, 1'b0, o, e);         // -> UpdDR
        repeat (PH) @(negedge clock);
        check("user_out_after", user_out, 16'hA5C3);
        check("user_update_cnt", upd_cnt - upd0, 1);
        pulse(1'b0, 1'b0, o, e);         // -> RTI

        // Undefined opcode selects BYPASS; abandon a scan with five tms=1 rises.
        load_ir(4'h3);
        check("ir_undef", ir_out, 4'h3);
        upd0 = upd_cnt;
        move(8'b0000_0001, 3);
        scan(7, 32'h0000_004B, 1'b0, d, ec);
        check("bypass7_tdo", d[6:0], 7'h16);
        check("bypass7_en_cnt", ec, 7);
        move(8'b0001_1111, 5);
        repeat (PH) @(negedge clock);
        check("tmsrst_state", tap_state, 4'hF);
        check("tmsrst_ir", ir_out, 4'h1);
        check("tmsrst_user_out", user_out, 16'hA5C3);
        check("tmsrst_no_update", upd_cnt - upd0, 0);

        // Reset during a USER shift.
        pulse(1'b0, 1'b0, o, e);
        load_ir(4'h8);
        user_in = 16'h5A5A;
        upd0 = upd_cnt;
        move(8'b0000_0001, 3);
        scan(9, 32'h0000_01FF, 1'b0, d, ec);
        repeat (PH) @(negedge clock);
        check("abort_pre_state", tap_state, 4'h2);
        check("abort_pre_en", tdo_en, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        check("abort_state", tap_state, 4'hF);
        check("abort_ir", ir_out, 4'h1);
        check("abort_tdo", tdo, 1'b0);
        check("abort_tdo_en", tdo_en, 1'b0);
        check("abort_user_out", user_out, 16'h0000);
        check("abort_user_update", user_update, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("abort_no_update", upd_cnt - upd0, 0);

        idcode_read("idcode2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
